// File: rtl/tx_frontend.sv
// UART transmit serialiser: start bit, 7/8 data bits LSB first, optional parity, 1/2 stop bits.
// Defining TX_FRONTEND_BREAK_EN adds a break_i input that holds the line low while idle.
module tx_frontend (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cr_clk_div_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic [7:0]  data_i,
  input  logic        valid_i,
`ifdef TX_FRONTEND_BREAK_EN
  input  logic        break_i,
`endif
  output logic        ready_o,
  output logic        uart_tx_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int DATA_W = 8;
  localparam int DIV_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK,
    S_BRK_REC
  } state_t;

  state_t            state;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  baud_cnt;
  logic [DATA_W-1:0] shreg;
  logic [2:0]        bit_cnt;
  logic              ds_r;
  logic [1:0]        p_r;
  logic              stop_cnt;
  logic              par_r;
  logic              tx_r;
  logic              busy_r;
  logic              done_r;
  logic              bit_end;
  logic              bit_last;

  // A divider of 0 or 1 both mean one cycle per bit, so the reload never wraps.
  function automatic logic [DIV_W-1:0] baud_load(input logic [DIV_W-1:0] div);
    return (div <= 16'd1) ? {DIV_W{1'b0}} : div - 16'd1;
  endfunction

  assign bit_end  = (baud_cnt == {DIV_W{1'b0}});
  assign bit_last = (bit_cnt == (ds_r ? 3'd7 : 3'd6));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      div_r    <= '0;
      baud_cnt <= '0;
      shreg    <= '0;
      bit_cnt  <= '0;
      ds_r     <= 1'b0;
      p_r      <= 2'b00;
      stop_cnt <= 1'b0;
      par_r    <= 1'b0;
      tx_r     <= 1'b1;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
`ifdef TX_FRONTEND_BREAK_EN
          if (break_i) begin
            state <= S_BREAK;
            tx_r  <= 1'b0;
          end else
`endif
          if (valid_i) begin
            state    <= S_START;
            tx_r     <= 1'b0;
            busy_r   <= 1'b1;
            shreg    <= data_i;
            div_r    <= cr_clk_div_i;
            ds_r     <= cr_ds_i;
            p_r      <= cr_p_i;
            stop_cnt <= cr_s_i;
            par_r    <= cr_p_i[0];
            bit_cnt  <= '0;
            baud_cnt <= baud_load(cr_clk_div_i);
          end
        end
`ifdef TX_FRONTEND_BREAK_EN
        S_BREAK: begin
          if (!break_i) begin
            state    <= S_BRK_REC;
            tx_r     <= 1'b1;
            baud_cnt <= baud_load(cr_clk_div_i);
          end
        end
        S_BRK_REC: begin
          if (bit_end) state <= S_IDLE;
          else         baud_cnt <= baud_cnt - 16'd1;
        end
`endif
        default: begin
          if (!bit_end) begin
            baud_cnt <= baud_cnt - 16'd1;
          end else begin
            baud_cnt <= baud_load(div_r);
            case (state)
              S_START: begin
                state   <= S_DATA;
                tx_r    <= shreg[0];
                par_r   <= par_r ^ shreg[0];
                shreg   <= shreg >> 1;
                bit_cnt <= '0;
              end
              S_DATA: begin
                if (bit_last) begin
                  if (p_r != 2'b00) begin
                    state <= S_PARITY;
                    tx_r  <= par_r;
                  end else begin
                    state <= S_STOP;
                    tx_r  <= 1'b1;
                  end
                end else begin
                  tx_r    <= shreg[0];
                  par_r   <= par_r ^ shreg[0];
                  shreg   <= shreg >> 1;
                  bit_cnt <= bit_cnt + 3'd1;
                end
              end
              S_PARITY: begin
                state <= S_STOP;
                tx_r  <= 1'b1;
              end
              S_STOP: begin
                if (stop_cnt) begin
                  stop_cnt <= 1'b0;
                end else begin
                  state  <= S_IDLE;
                  busy_r <= 1'b0;
                  done_r <= 1'b1;
                  tx_r   <= 1'b1;
                end
              end
              default: state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

`ifdef TX_FRONTEND_BREAK_EN
  assign ready_o = (state == S_IDLE) && !break_i;
`else
  assign ready_o = (state == S_IDLE);
`endif
  assign uart_tx_o = tx_r;
  assign busy_o    = busy_r;
  assign done_o    = done_r;

endmodule

// File: tb/tb_tx_frontend.sv
// Self-checking bench for tx_frontend: per-cycle line scoreboard plus frame-length and corner-case checks.
module tb_tx_frontend;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [15:0] cr_clk_div_i;
  logic        cr_ds_i;
  logic [1:0]  cr_p_i;
  logic        cr_s_i;
  logic [7:0]  data_i;
  logic        valid_i;
  logic        ready_o;
  logic        uart_tx_o;
  logic        busy_o;
  logic        done_o;
`ifdef TX_FRONTEND_BREAK_EN
  logic        break_i;
`endif

  tx_frontend dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cr_clk_div_i (cr_clk_div_i),
    .cr_ds_i      (cr_ds_i),
    .cr_p_i       (cr_p_i),
    .cr_s_i       (cr_s_i),
    .data_i       (data_i),
    .valid_i      (valid_i),
`ifdef TX_FRONTEND_BREAK_EN
    .break_i      (break_i),
`endif
    .ready_o      (ready_o),
    .uart_tx_o    (uart_tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic tx;
    logic busy;
    logic ready;
    logic done;
  } obs_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] div;
    logic        ds;
    logic [1:0]  p;
    logic        s;
    int          len;
  } vec_t;

  obs_t exp_q[$];
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  int   last_acc = 0;
  int   done_cyc = -1;
  logic mon_idle_en = 1'b0;
  vec_t tbl[8];

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input obs_t act, input obs_t e);
    vec_cnt++;
    if (act !== e) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d tx/busy/ready/done got %b required %b", name, cyc, act, e);
    end
  endtask

  task automatic check_int(input string name, input int got, input int e);
    vec_cnt++;
    if (got != e) begin
      err_cnt++;
      $display("FAIL %s got %0d required %0d", name, got, e);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic e);
    vec_cnt++;
    if (got !== e) begin
      err_cnt++;
      $display("FAIL %s cyc=%0d got %b required %b", name, cyc, got, e);
    end
  endtask

  // Scoreboard consumer: one expected line state per clock, idle otherwise.
  always @(negedge clk_i) begin : mon
    obs_t act;
    obs_t e;
    act = {uart_tx_o, busy_o, ready_o, done_o};
    if (done_o === 1'b1) done_cyc = cyc;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("line", act, e);
    end else if (mon_idle_en) begin
      check("idle", act, 4'b1010);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Reference frame: builds the serial bit list and expands it to per-cycle states.
  task automatic push_frame(input logic [7:0] d, input logic [15:0] div, input logic ds,
                            input logic [1:0] p, input logic s);
    logic bits[$];
    logic par;
    int   per;
    int   nb;
    per = (div < 16'd2) ? 1 : int'(div);
    nb  = ds ? 8 : 7;
    par = p[0];
    bits.push_back(1'b0);
    for (int i = 0; i < nb; i++) begin
      bits.push_back(d[i]);
      par = par ^ d[i];
    end
    if (p != 2'b00) bits.push_back(par);
    bits.push_back(1'b1);
    if (s) bits.push_back(1'b1);
    foreach (bits[k]) repeat (per) exp_q.push_back({bits[k], 1'b1, 1'b0, 1'b0});
    exp_q.push_back(4'b1011);
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] div, input logic ds,
                      input logic [1:0] p, input logic s, input bit hold);
    bit ok;
    ok           = 1'b0;
    data_i       = d;
    cr_clk_div_i = div;
    cr_ds_i      = ds;
    cr_p_i       = p;
    cr_s_i       = s;
    valid_i      = 1'b1;
    for (int i = 0; i < 1000 && !ok; i++) begin
      if (ready_o === 1'b1) begin
        @(posedge clk_i);
        push_frame(d, div, ds, p, s);
        #1;
        last_acc = cyc;
        ok = 1'b1;
      end else begin
        step(1);
      end
    end
    if (!ok) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL accept_timeout ready_o stayed %b required 1", ready_o);
    end
    if (!hold) valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) step(1);
    if (exp_q.size() != 0) begin
      vec_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout %0d states left required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int a1;
    rst_i        = 1'b0;
    valid_i      = 1'b0;
    data_i       = 8'h00;
    cr_clk_div_i = 16'd4;
    cr_ds_i      = 1'b1;
    cr_p_i       = 2'b00;
    cr_s_i       = 1'b0;
`ifdef TX_FRONTEND_BREAK_EN
    break_i      = 1'b0;
`endif
    #2 rst_i = 1'b1;
    #1 check("reset_state", {uart_tx_o, busy_o, ready_o, done_o}, 4'b1010);
    mon_idle_en = 1'b1;
    step(3);
    #1 rst_i = 1'b0;
    step(2);

    tbl[0] = '{8'hA5, 16'd4, 1'b1, 2'b00, 1'b0, 40};
    tbl[1] = '{8'h87, 16'd3, 1'b0, 2'b10, 1'b1, 33};
    tbl[2] = '{8'h00, 16'd2, 1'b1, 2'b01, 1'b0, 22};
    tbl[3] = '{8'h00, 16'd2, 1'b1, 2'b10, 1'b0, 22};
    tbl[4] = '{8'hFF, 16'd0, 1'b1, 2'b01, 1'b1, 12};
    tbl[5] = '{8'h5A, 16'd1, 1'b0, 2'b00, 1'b0, 9};
    tbl[6] = '{8'h3C, 16'd5, 1'b0, 2'b01, 1'b1, 55};
    tbl[7] = '{8'hC3, 16'd7, 1'b1, 2'b11, 1'b0, 77};

    for (int i = 0; i < 8; i++) begin
      done_cyc = -1;
      send(tbl[i].data, tbl[i].div, tbl[i].ds, tbl[i].p, tbl[i].s, 1'b0);
      drain();
      check_int($sformatf("frame_len[%0d]", i), done_cyc - last_acc, tbl[i].len);
      step(2);
    end

    // Config and data changes plus a stray valid pulse while busy must not disturb the frame.
    done_cyc = -1;
    send(8'hA5, 16'd4, 1'b1, 2'b00, 1'b0, 1'b0);
    step(10);
    cr_clk_div_i = 16'd8;
    cr_ds_i      = 1'b0;
    data_i       = 8'h11;
    valid_i      = 1'b1;
    step(1);
    valid_i      = 1'b0;
    drain();
    check_int("midframe_len", done_cyc - last_acc, 40);
    step(3);
    done_cyc = -1;
    send(8'h11, 16'd8, 1'b0, 2'b00, 1'b0, 1'b0);
    drain();
    check_int("newcfg_len", done_cyc - last_acc, 72);
    step(2);

    // Back-to-back with valid held: next accept one cycle after the last stop bit.
    send(8'h3C, 16'd4, 1'b1, 2'b00, 1'b0, 1'b1);
    a1 = last_acc;
    done_cyc = -1;
    send(8'hC3, 16'd4, 1'b1, 2'b00, 1'b0, 1'b0);
    check_int("b2b_gap", last_acc - a1, 41);
    drain();
    check_int("b2b_len", done_cyc - last_acc, 40);
    step(2);

    // Asynchronous reset in the middle of the data bits.
    send(8'hF0, 16'd4, 1'b1, 2'b00, 1'b0, 1'b0);
    step(10);
    #1 rst_i = 1'b1;
    exp_q.delete();
    #1 check("async_reset", {uart_tx_o, busy_o, ready_o, done_o}, 4'b1010);
    step(2);
    #1 rst_i = 1'b0;
    step(2);
    done_cyc = -1;
    send(8'h69, 16'd3, 1'b1, 2'b01, 1'b0, 1'b0);
    drain();
    check_int("post_reset_len", done_cyc - last_acc, 33);
    step(2);

`ifdef TX_FRONTEND_BREAK_EN
    mon_idle_en  = 1'b0;
    cr_clk_div_i = 16'd3;
    break_i      = 1'b1;
    #1 check_bit("break_ready", ready_o, 1'b0);
    step(3);
    check_bit("break_line", uart_tx_o, 1'b0);
    check_bit("break_ready_hold", ready_o, 1'b0);
    break_i = 1'b0;
    step(1);
    check_bit("brk_rec_line", uart_tx_o, 1'b1);
    check_bit("brk_rec_ready0", ready_o, 1'b0);
    step(2);
    check_bit("brk_rec_ready1", ready_o, 1'b0);
    step(1);
    check_bit("brk_end_ready", ready_o, 1'b1);
    mon_idle_en = 1'b1;
    step(2);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
